// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin arbiter sharing the usb_uart host-bound byte pipeline between N_REQ sources.
// Ownership is held per message (until last), per burst limit, or until the owner goes quiet.
module usb_uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 3,
   parameter int unsigned MAX_BURST    = 64,
   parameter int unsigned IDLE_TIMEOUT = 255
) (
   input  logic                 clk_48mhz,
   input  logic                 reset,
   input  logic [N_REQ*8-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           uart_in_data,
   output logic                 uart_in_valid,
   input  logic                 uart_in_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy
);

   localparam int unsigned IdxW = $clog2(N_REQ);
   localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);
   localparam logic [7:0] IdleLast  = 8'(IDLE_TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e            state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IdxW-1:0]   owner_q, owner_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;
   logic [7:0]        idle_cnt_q, idle_cnt_d;

   logic              hi_found, lo_found, winner_found;
   logic [IdxW-1:0]   hi_idx, lo_idx, winner;
   logic              owner_valid, owner_last, beat, release_now;

   // Requesters above the pointer take priority; otherwise wrap to the lowest one at or below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (IdxW'(i) > rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = IdxW'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = IdxW'(i);
            end
         end
      end
      winner_found = hi_found | lo_found;
      winner       = hi_found ? hi_idx : lo_idx;
   end

   // grant_q is all-zero outside GRANT, so the passthrough needs no state qualifier.
   always_comb begin
      uart_in_data = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (grant_q[i]) uart_in_data = req_data[8*i +: 8];
      end
   end

   assign owner_valid   = |(req_valid & grant_q);
   assign owner_last    = |(req_last & grant_q);
   assign beat          = owner_valid & uart_in_ready;
   assign uart_in_valid = owner_valid;
   assign req_ready     = uart_in_ready ? grant_q : '0;
   assign grant         = grant_q;
   assign busy          = (state_q == StGrant);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      release_now = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (winner_found) begin
               state_d     = StGrant;
               grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
               owner_d     = winner;
               burst_cnt_d = '0;
               idle_cnt_d  = '0;
            end
         end
         StGrant: begin
            release_now = (beat && (owner_last || burst_cnt_q == BurstLast)) ||
                          (!owner_valid && idle_cnt_q == IdleLast);
            if (release_now) begin
               state_d     = StIdle;
               grant_d     = '0;
               rr_ptr_d    = owner_q;
               burst_cnt_d = '0;
               idle_cnt_d  = '0;
            end else begin
               if (beat) burst_cnt_d = burst_cnt_q + 8'd1;
               idle_cnt_d = owner_valid ? 8'd0 : idle_cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= IdxW'(N_REQ - 1);
         burst_cnt_q <= '0;
         idle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Bench for usb_uart_tx_arbiter: vector table, directed corner sequences and random traffic,
// all cross-checked every cycle against a message-level reference model.
module tb_usb_uart_tx_arbiter;

   localparam int N  = 3;
   localparam int MB = 64;
   localparam int IT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*8-1:0] rd;
   logic [N-1:0]  rv, rl;
   logic          rdy;
   logic [N-1:0]  rready, gnt;
   logic [7:0]    ud;
   logic          uv, bsy;

   always #5 clk = ~clk;

   usb_uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
      .clk_48mhz    (clk),
      .reset        (rst),
      .req_data     (rd),
      .req_valid    (rv),
      .req_last     (rl),
      .req_ready    (rready),
      .uart_in_data (ud),
      .uart_in_valid(uv),
      .uart_in_ready(rdy),
      .grant        (gnt),
      .busy         (bsy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the pipe, who last owned it, bytes sent and quiet cycles so far.
   int owner, last_winner, beats, quiet;

   logic [8:0] srcq [N][$];
   bit         held [N];
   int         stall [N];
   bit         use_src, rand_mode;
   int         log_src[$];
   logic [7:0] log_data[$];

   typedef struct {
      logic       r;
      logic [2:0] v, l;
      logic       rdy;
      logic [2:0] g;
      logic       b, uv;
      logic [7:0] d;
      logic [2:0] rr;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic void add(logic r, logic [2:0] v, logic [2:0] l, logic ry, logic [2:0] g,
                               logic b, logic u, logic [7:0] d, logic [2:0] rr);
      vec_t t;
      t.r = r; t.v = v; t.l = l; t.rdy = ry; t.g = g; t.b = b; t.uv = u; t.d = d; t.rr = rr;
      tbl.push_back(t);
   endfunction

   task automatic model_reset();
      owner = -1; last_winner = N - 1; beats = 0; quiet = 0;
   endtask

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         bit en;
         if (rand_mode) begin
            if (stall[i] > 0) stall[i]--;
            else if ($urandom_range(63) == 0) stall[i] = int'($urandom_range(15, 5));
         end
         en = held[i] || !rand_mode || (stall[i] == 0 && $urandom_range(9) < 8);
         if (srcq[i].size() != 0 && en) begin
            rv[i] = 1'b1;
            rd[i*8 +: 8] = srcq[i][0][7:0];
            rl[i] = srcq[i][0][8];
         end else begin
            rv[i] = 1'b0;
            rd[i*8 +: 8] = 8'($urandom);
            rl[i] = 1'($urandom);
         end
      end
   endtask

   // Compare DUT outputs with the model, log delivered bytes, then advance the model.
   task automatic model_step();
      logic [2:0] e_g, e_r;
      logic [7:0] e_d;
      logic       e_v;
      bit         acc;
      int         g;
      e_g = '0; e_r = '0; e_d = '0; e_v = 1'b0;
      if (owner >= 0) begin
         e_g = 3'(1 << owner);
         e_d = rd[owner*8 +: 8];
         e_v = rv[owner];
         e_r = rdy ? e_g : 3'b000;
      end
      chk("grant", 32'(gnt), 32'(e_g));
      chk("busy", 32'(bsy), 32'(owner >= 0));
      chk("uart_in_valid", 32'(uv), 32'(e_v));
      chk("uart_in_data", 32'(ud), 32'(e_d));
      chk("req_ready", 32'(rready), 32'(e_r));
      if (uv && rdy) begin
         for (int i = 0; i < N; i++) if (gnt[i]) log_src.push_back(i);
         log_data.push_back(ud);
      end
      acc = (owner >= 0) && rv[owner] && rdy;
      for (int i = 0; i < N; i++) held[i] = rv[i] && !(acc && i == owner);
      if (acc && use_src) void'(srcq[owner].pop_front());
      g = owner;
      if (rst) model_reset();
      else if (g < 0) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last_winner + k) % N;
            if (rv[idx] && owner < 0) owner = idx;
         end
         beats = 0; quiet = 0;
      end else if (acc) begin
         beats++; quiet = 0;
         if (rl[g] || beats == MB) begin last_winner = g; owner = -1; end
      end else if (rv[g]) quiet = 0;
      else begin
         quiet++;
         if (quiet == IT) begin last_winner = g; owner = -1; end
      end
   endtask

   task automatic cycle();
      if (use_src) drive_src();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int left;
      left = budget;
      while (left > 0 && (owner >= 0 || srcq[0].size() + srcq[1].size() + srcq[2].size() != 0)) begin
         cycle();
         left--;
      end
      n_vec++;
      if (left == 0) begin
         n_err++;
         $display("FAIL %s drain: got still busy after %0d cycles, expected idle", name, budget);
      end
   endtask

   initial begin
      rst = 1'b1; rv = '0; rl = '0; rd = '0; rdy = 1'b0;
      use_src = 1'b0; rand_mode = 1'b0;
      for (int i = 0; i < N; i++) begin held[i] = 1'b0; stall[i] = 0; end
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;

      // r, v, l, rdy | grant, busy, uart_valid, data, req_ready
      add(1, 3'b111, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b111, 3'b000, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b111, 3'b001, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b111, 3'b000, 1, 3'b010, 1, 1, 8'hB1, 3'b010);
      add(0, 3'b111, 3'b010, 1, 3'b010, 1, 1, 8'hB1, 3'b010);
      add(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b111, 3'b000, 1, 3'b100, 1, 1, 8'hC2, 3'b100);
      add(0, 3'b111, 3'b100, 1, 3'b100, 1, 1, 8'hC2, 3'b100);
      add(0, 3'b111, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b111, 3'b000, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b111, 3'b001, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b010, 3'b010, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b010, 3'b010, 1, 3'b010, 1, 1, 8'hB1, 3'b010);
      add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b001, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);
      add(0, 3'b001, 3'b000, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b001, 3'b000, 0, 3'b001, 1, 1, 8'hA0, 3'b000);
      add(0, 3'b001, 3'b000, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b001, 3'b000, 0, 3'b001, 1, 1, 8'hA0, 3'b000);
      add(0, 3'b001, 3'b000, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b001, 3'b000, 0, 3'b001, 1, 1, 8'hA0, 3'b000);
      add(0, 3'b001, 3'b001, 1, 3'b001, 1, 1, 8'hA0, 3'b001);
      add(0, 3'b000, 3'b000, 1, 3'b000, 0, 0, 8'h00, 3'b000);

      rd = 24'hC2B1A0;
      for (int t = 0; t < tbl.size(); t++) begin
         rst = tbl[t].r; rv = tbl[t].v; rl = tbl[t].l; rdy = tbl[t].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d grant", t), 32'(gnt), 32'(tbl[t].g));
         chk($sformatf("tbl%0d busy", t), 32'(bsy), 32'(tbl[t].b));
         chk($sformatf("tbl%0d uart_in_valid", t), 32'(uv), 32'(tbl[t].uv));
         chk($sformatf("tbl%0d uart_in_data", t), 32'(ud), 32'(tbl[t].d));
         chk($sformatf("tbl%0d req_ready", t), 32'(rready), 32'(tbl[t].rr));
         model_step();
         @(posedge clk); #1;
      end

      // Idle timeout: two bytes, quiet, a pulse resets the count, then 8 quiet cycles release.
      rv = '0; rl = '0; rdy = 1'b1;
      do_reset();
      rv = 3'b001; rd[7:0] = 8'h10;
      cycle();
      cycle();
      rd[7:0] = 8'h11;
      cycle();
      rv = 3'b000;
      for (int i = 0; i < 6; i++) cycle();
      rv = 3'b001; rd[7:0] = 8'h12;
      cycle();
      rv = 3'b010;
      for (int i = 0; i < 7; i++) cycle();
      chk("timeout held 7 quiet", 32'(gnt), 32'h1);
      cycle();
      chk("timeout release grant", 32'(gnt), 32'h0);
      chk("timeout release busy", 32'(bsy), 32'h0);
      cycle();
      chk("timeout next owner", 32'(gnt), 32'h2);
      rv = 3'b000;
      cycle(); cycle();

      // Reset in the middle of requester 2's message.
      use_src = 1'b1;
      do_reset();
      for (int i = 0; i < 10; i++) srcq[2].push_back({1'(i == 9), 8'(8'h20 + i)});
      for (int i = 0; i < 4; i++) cycle();
      chk("pre-reset owner", 32'(gnt), 32'h4);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("reset grant", 32'(gnt), 32'h0);
      chk("reset busy", 32'(bsy), 32'h0);
      chk("reset uart_in_valid", 32'(uv), 32'h0);
      for (int i = 0; i < N; i++) begin
         srcq[i].delete();
         srcq[i].push_back({1'b1, 8'(8'h30 + i)});
      end
      cycle();
      chk("post-reset winner", 32'(gnt), 32'h1);
      drain(50, "reset");

      // Burst limit: 100-byte message from 1 is split around requester 0's message.
      do_reset();
      log_src.delete(); log_data.delete();
      for (int i = 0; i < 100; i++) srcq[1].push_back({1'(i == 99), 8'(i)});
      for (int i = 0; i < 3; i++) cycle();
      for (int i = 0; i < 3; i++) srcq[0].push_back({1'(i == 2), 8'(8'hE0 + i)});
      drain(400, "burst");
      begin
         int first0, bad;
         first0 = -1; bad = 0;
         for (int i = log_src.size() - 1; i >= 0; i--) if (log_src[i] == 0) first0 = i;
         chk("burst byte count", 32'(log_src.size()), 32'd103);
         chk("burst first r0 byte", 32'(first0), 32'd64);
         for (int i = 0; i < log_src.size(); i++) begin
            if (i >= 64 && i < 67) begin
               if (log_src[i] != 0 || log_data[i] != 8'(8'hE0 + i - 64)) bad++;
            end else if (log_src[i] != 1 || log_data[i] != 8'(i < 64 ? i : i - 3)) bad++;
         end
         chk("burst stream order", 32'(bad), 32'd0);
      end

      // Random traffic against the model.
      rand_mode = 1'b1;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rdy = ($urandom_range(3) != 0);
         rst = ($urandom_range(999) == 0);
         for (int i = 0; i < N; i++) begin
            if (srcq[i].size() == 0 && $urandom_range(15) == 0) begin
               int len;
               len = int'($urandom_range(80, 1));
               for (int b = 0; b < len; b++) srcq[i].push_back({1'(b == len - 1), 8'($urandom)});
            end
         end
         cycle();
      end
      rst = 1'b0; rdy = 1'b1; rand_mode = 1'b0;
      drain(2000, "random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
